// File: rtl/btb_next_pc_predictor_if.sv
// Fetch-side bundle of the next-PC predictor: lookup request, RAS
// top-of-stack, EX-stage training port and the one-cycle-later prediction.
interface btb_next_pc_predictor_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] ras_top;
  logic            ras_valid;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic [1:0]      upd_type;
  logic            pred_valid;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            pred_is_call;
  logic            pred_is_return;
  logic [XLEN-1:0] ras_push_addr;
  logic            hit;

  // Fetch/EX side: issues lookups and training, consumes predictions.
  modport master (
    output flush, fetch_valid, fetch_pc, ras_top, ras_valid,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_type,
    input  pred_valid, pred_taken, pred_target, pred_is_call,
    input  pred_is_return, ras_push_addr, hit
  );

  // Predictor side.
  modport slave (
    input  flush, fetch_valid, fetch_pc, ras_top, ras_valid,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_type,
    output pred_valid, pred_taken, pred_target, pred_is_call,
    output pred_is_return, ras_push_addr, hit
  );
endinterface

// File: rtl/btb_next_pc_predictor.sv
// Direct-mapped BTB next-PC predictor. A lookup registered at edge N
// produces its prediction during cycle N+1; returns take their target from
// the RAS top-of-stack seen in that output cycle. Entries are trained from
// EX resolution and written at the edge after upd_valid.
module btb_next_pc_predictor #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
  input logic                   clk,
  input logic                   reset,
  btb_next_pc_predictor_if.slave bus
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [1:0] TYPE_BR   = 2'b00;
  localparam logic [1:0] TYPE_JMP  = 2'b01;
  localparam logic [1:0] TYPE_CALL = 2'b10;
  localparam logic [1:0] TYPE_RET  = 2'b11;

  // Two-bit saturating direction counter step.
  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  // Table storage; only the valid bits carry reset state.
  logic [BTB_ENTRIES-1:0] tbl_vld;
  logic [TAG_W-1:0]       tbl_tag [BTB_ENTRIES];
  logic [XLEN-1:0]        tbl_tgt [BTB_ENTRIES];
  logic [1:0]             tbl_ctr [BTB_ENTRIES];
  logic [1:0]             tbl_typ [BTB_ENTRIES];

  // Training decode.
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_wr;
  logic [1:0]       upd_ctr;

  // Decide whether the EX update rewrites, allocates or leaves the entry alone.
  always_comb begin
    upd_idx = bus.upd_pc[IDX_W+1:2];
    upd_tag = bus.upd_pc[XLEN-1:IDX_W+2];
    upd_hit = tbl_vld[upd_idx] && (tbl_tag[upd_idx] == upd_tag);
    upd_wr  = bus.upd_valid && (upd_hit || bus.upd_taken);
    if (upd_hit)
      upd_ctr = (bus.upd_type == TYPE_BR) ? sat_ctr(tbl_ctr[upd_idx], bus.upd_taken) : 2'b11;
    else
      upd_ctr = (bus.upd_type == TYPE_BR) ? 2'b10 : 2'b11;
  end

  // Entry valid bits: cleared immediately by reset, set on allocation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tbl_vld <= '0;
    else if (upd_wr)
      tbl_vld[upd_idx] <= 1'b1;
  end

  // Entry payload write; a same-cycle lookup still reads the old contents.
  always_ff @(posedge clk) begin
    if (upd_wr) begin
      tbl_tag[upd_idx] <= upd_tag;
      tbl_tgt[upd_idx] <= bus.upd_target;
      tbl_ctr[upd_idx] <= upd_ctr;
      tbl_typ[upd_idx] <= bus.upd_type;
    end
  end

  // ---- stage p1: registered lookup (PC + entry snapshot) ----
  logic             vld_p1;
  logic [XLEN-1:0]  pc_p1;
  logic             ent_vld_p1;
  logic [TAG_W-1:0] ent_tag_p1;
  logic [XLEN-1:0]  ent_tgt_p1;
  logic [1:0]       ent_ctr_p1;
  logic [1:0]       ent_typ_p1;

  // Prediction valid: flush wins over a lookup, reset drops it at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= bus.fetch_valid && !bus.flush;
  end

  // Capture the looked-up PC and the indexed entry.
  always_ff @(posedge clk) begin
    if (bus.fetch_valid) begin
      pc_p1      <= bus.fetch_pc;
      ent_vld_p1 <= tbl_vld[bus.fetch_pc[IDX_W+1:2]];
      ent_tag_p1 <= tbl_tag[bus.fetch_pc[IDX_W+1:2]];
      ent_tgt_p1 <= tbl_tgt[bus.fetch_pc[IDX_W+1:2]];
      ent_ctr_p1 <= tbl_ctr[bus.fetch_pc[IDX_W+1:2]];
      ent_typ_p1 <= tbl_typ[bus.fetch_pc[IDX_W+1:2]];
    end
  end

  logic [XLEN-1:0] pc_plus4_p1;
  logic            hit_p1;

  // Form the prediction; everything is held at zero while no prediction is pending.
  always_comb begin
    pc_plus4_p1        = pc_p1 + XLEN'(4);
    hit_p1             = ent_vld_p1 && (ent_tag_p1 == pc_p1[XLEN-1:IDX_W+2]);
    bus.pred_valid     = 1'b0;
    bus.pred_taken     = 1'b0;
    bus.pred_target    = '0;
    bus.pred_is_call   = 1'b0;
    bus.pred_is_return = 1'b0;
    bus.ras_push_addr  = '0;
    bus.hit            = 1'b0;
    if (vld_p1) begin
      bus.pred_valid    = 1'b1;
      bus.ras_push_addr = pc_plus4_p1;
      bus.hit           = hit_p1;
      bus.pred_target   = pc_plus4_p1;
      if (hit_p1) begin
        unique case (ent_typ_p1)
          TYPE_BR: begin
            bus.pred_taken = ent_ctr_p1[1];
            if (ent_ctr_p1[1]) bus.pred_target = ent_tgt_p1;
          end
          TYPE_JMP: begin
            bus.pred_taken  = 1'b1;
            bus.pred_target = ent_tgt_p1;
          end
          TYPE_CALL: begin
            bus.pred_taken   = 1'b1;
            bus.pred_target  = ent_tgt_p1;
            bus.pred_is_call = 1'b1;
          end
          TYPE_RET: begin
            bus.pred_taken     = 1'b1;
            bus.pred_is_return = 1'b1;
            bus.pred_target    = bus.ras_valid ? bus.ras_top : ent_tgt_p1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btb_next_pc_predictor.sv
// Directed bench for btb_next_pc_predictor: an entry-level table model
// predicts every output cycle, and literal values pin the key scenarios.
module tb_btb_next_pc_predictor;

  localparam int XLEN = 32;
  localparam int NENT = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  btb_next_pc_predictor_if #(.XLEN(XLEN)) bus ();

  btb_next_pc_predictor #(.XLEN(XLEN), .BTB_ENTRIES(NENT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [NENT];
  int unsigned m_tag   [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_ctr   [NENT];
  int          m_typ   [NENT];

  bit          e_vld = 1'b0;
  logic [31:0] e_pc;
  bit          e_hit;
  int          e_typ, e_ctr;
  logic [31:0] e_tgt;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> 6;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
      e_vld = 1'b0;
    end else begin
      int k;
      e_vld = bus.fetch_valid && !bus.flush;
      if (bus.fetch_valid) begin
        k     = idx_of(bus.fetch_pc);
        e_pc  = bus.fetch_pc;
        e_hit = m_valid[k] && (m_tag[k] == tag_of(bus.fetch_pc));
        e_typ = m_typ[k];
        e_ctr = m_ctr[k];
        e_tgt = m_tgt[k];
      end
      if (bus.upd_valid) begin
        k = idx_of(bus.upd_pc);
        if (m_valid[k] && m_tag[k] == tag_of(bus.upd_pc)) begin
          if (bus.upd_type == 2'd0)
            m_ctr[k] = bus.upd_taken ? ((m_ctr[k] + 1 > 3) ? 3 : m_ctr[k] + 1)
                                     : ((m_ctr[k] - 1 < 0) ? 0 : m_ctr[k] - 1);
          else
            m_ctr[k] = 3;
          m_tag[k] = tag_of(bus.upd_pc);
          m_tgt[k] = bus.upd_target;
          m_typ[k] = int'(bus.upd_type);
        end else if (bus.upd_taken) begin
          m_valid[k] = 1'b1;
          m_tag[k]   = tag_of(bus.upd_pc);
          m_tgt[k]   = bus.upd_target;
          m_typ[k]   = int'(bus.upd_type);
          m_ctr[k]   = (bus.upd_type == 2'd0) ? 2 : 3;
        end
      end
    end
  end

  // Compare every output cycle against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_pred_valid", bus.pred_valid, 0);
      chk("rst_pred_taken", bus.pred_taken, 0);
      chk("rst_pred_target", bus.pred_target, 0);
      chk("rst_is_call", bus.pred_is_call, 0);
      chk("rst_is_return", bus.pred_is_return, 0);
      chk("rst_push_addr", bus.ras_push_addr, 0);
      chk("rst_hit", bus.hit, 0);
    end else begin
      chk("m_pred_valid", bus.pred_valid, e_vld);
      if (e_vld) begin
        bit tk, cl, rt;
        logic [31:0] tg;
        tk = 0; cl = 0; rt = 0; tg = e_pc + 32'd4;
        if (e_hit) begin
          case (e_typ)
            0: begin tk = (e_ctr >= 2); if (tk) tg = e_tgt; end
            1: begin tk = 1; tg = e_tgt; end
            2: begin tk = 1; tg = e_tgt; cl = 1; end
            default: begin tk = 1; rt = 1; tg = bus.ras_valid ? bus.ras_top : e_tgt; end
          endcase
        end
        chk("m_hit", bus.hit, e_hit);
        chk("m_taken", bus.pred_taken, tk);
        chk("m_target", bus.pred_target, tg);
        chk("m_is_call", bus.pred_is_call, cl);
        chk("m_is_return", bus.pred_is_return, rt);
        chk("m_push_addr", bus.ras_push_addr, e_pc + 32'd4);
      end else begin
        chk("m_idle_is_call", bus.pred_is_call, 0);
        chk("m_idle_is_return", bus.pred_is_return, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic [1:0] typ);
    @(posedge clk); #1;
    bus.upd_valid = 1; bus.upd_pc = pc; bus.upd_taken = taken;
    bus.upd_target = tgt; bus.upd_type = typ;
    @(posedge clk); #1;
    bus.upd_valid = 0;
  endtask

  // Issues one lookup and returns at the negedge of its output cycle.
  task automatic lookup(input logic [31:0] pc, input logic fl);
    @(posedge clk); #1;
    bus.fetch_valid = 1; bus.fetch_pc = pc; bus.flush = fl;
    @(posedge clk); #1;
    bus.fetch_valid = 0; bus.flush = 0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] stream [4];
    stream[0] = 32'h400; stream[1] = 32'h810; stream[2] = 32'h104; stream[3] = 32'h200;
    bus.flush = 0; bus.fetch_valid = 0; bus.fetch_pc = 0;
    bus.ras_top = 0; bus.ras_valid = 0;
    bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_taken = 0;
    bus.upd_target = 0; bus.upd_type = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // Cold lookup.
    lookup(32'h100, 0);
    chk("cold_valid", bus.pred_valid, 1);
    chk("cold_hit", bus.hit, 0);
    chk("cold_taken", bus.pred_taken, 0);
    chk("cold_target", bus.pred_target, 32'h104);

    // Branch training.
    upd(32'h200, 1, 32'h300, 2'b00);
    lookup(32'h200, 0);
    chk("br_hit", bus.hit, 1);
    chk("br_taken", bus.pred_taken, 1);
    chk("br_target", bus.pred_target, 32'h300);
    upd(32'h200, 0, 32'h300, 2'b00);
    upd(32'h200, 0, 32'h300, 2'b00);
    lookup(32'h200, 0);
    chk("br_nt_taken", bus.pred_taken, 0);
    chk("br_nt_target", bus.pred_target, 32'h204);
    repeat (4) upd(32'h200, 1, 32'h300, 2'b00);
    upd(32'h200, 0, 32'h300, 2'b00);
    lookup(32'h200, 0);
    chk("br_sat_taken", bus.pred_taken, 1);
    chk("br_sat_target", bus.pred_target, 32'h300);

    // Call and return with the RAS.
    upd(32'h400, 1, 32'h800, 2'b10);
    lookup(32'h400, 0);
    chk("call_is_call", bus.pred_is_call, 1);
    chk("call_push", bus.ras_push_addr, 32'h404);
    chk("call_target", bus.pred_target, 32'h800);
    upd(32'h810, 1, 32'h900, 2'b11);
    bus.ras_valid = 1; bus.ras_top = 32'h404;
    lookup(32'h810, 0);
    chk("ret_target_ras", bus.pred_target, 32'h404);
    chk("ret_is_return", bus.pred_is_return, 1);
    bus.ras_valid = 0;
    lookup(32'h810, 0);
    chk("ret_target_stored", bus.pred_target, 32'h900);

    // Flush kills the prediction and its RAS side effect.
    lookup(32'h400, 1);
    chk("flush_valid", bus.pred_valid, 0);
    chk("flush_is_call", bus.pred_is_call, 0);

    // Back-to-back lookups.
    bus.ras_valid = 1; bus.ras_top = 32'hABC0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      bus.fetch_valid = 1; bus.fetch_pc = stream[i];
      @(posedge clk); #1;
    end
    bus.fetch_valid = 0;
    bus.ras_valid = 0;

    // Aliasing: 0x240 evicts 0x200 (same index).
    upd(32'h200, 1, 32'h300, 2'b00);
    upd(32'h240, 1, 32'h340, 2'b01);
    lookup(32'h200, 0);
    chk("alias_hit", bus.hit, 0);
    chk("alias_target", bus.pred_target, 32'h204);

    // Same-cycle update and lookup of 0x500, then lookup again.
    @(posedge clk); #1;
    bus.upd_valid = 1; bus.upd_pc = 32'h500; bus.upd_taken = 1;
    bus.upd_target = 32'h600; bus.upd_type = 2'b01;
    bus.fetch_valid = 1; bus.fetch_pc = 32'h500;
    @(posedge clk); #1;
    bus.upd_valid = 0;
    @(negedge clk);
    chk("same_cyc_hit", bus.hit, 0);
    chk("same_cyc_target", bus.pred_target, 32'h504);
    @(posedge clk); #1;
    bus.fetch_valid = 0;
    @(negedge clk);
    chk("next_cyc_hit", bus.hit, 1);
    chk("next_cyc_target", bus.pred_target, 32'h600);

    // Asynchronous reset mid-stream.
    @(posedge clk); #1;
    bus.fetch_valid = 1; bus.fetch_pc = 32'h500;
    @(posedge clk); #1;
    bus.fetch_valid = 0;
    #1 reset = 1;
    #1;
    chk("async_rst_valid", bus.pred_valid, 0);
    chk("async_rst_target", bus.pred_target, 0);
    chk("async_rst_push", bus.ras_push_addr, 0);
    chk("async_rst_hit", bus.hit, 0);
    @(posedge clk); #1 reset = 0;
    lookup(32'h200, 0);
    chk("post_rst_hit", bus.hit, 0);
    chk("post_rst_target", bus.pred_target, 32'h204);
    lookup(32'h500, 0);
    chk("post_rst_hit_500", bus.hit, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
